// File: rtl/calc_pkg.sv
// calc_pkg
//   Shared definitions for the calc stack calculator and its program sequencer:
//   - op code constants (must match the encoding decoded by calc)
//   - sequencer FSM state type
//   - packed program word layout {op, data, last}
package calc_pkg;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_MUL  = 3'd2;
  localparam logic [2:0] OP_NEG  = 3'd4;
  localparam logic [2:0] OP_PUSH = 3'd5;
  localparam logic [2:0] OP_POP  = 3'd6;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    ISSUE = 3'd2,
    CHECK = 3'd3,
    DONE  = 3'd4,
    ERROR = 3'd5
  } seq_state_e;

  typedef struct packed {
    logic [2:0] op;
    logic [7:0] data;
    logic       last;
  } prog_word_t;

endpackage

// File: rtl/calc_prog_mem.sv
// calc_prog_mem
//   DEPTH x 12-bit program store: one synchronous write port, one
//   asynchronous read port. Contents are deliberately not reset so a program
//   survives a reset of the sequencer.
//   Ports:
//     clk    - clock
//     we     - write enable (already qualified by the caller)
//     waddr  - write address
//     wdata  - program word to store
//     raddr  - read address
//     rdata  - program word at raddr (combinational)
module calc_prog_mem
  import calc_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  prog_word_t    wdata,
  input  logic [AW-1:0] raddr,
  output prog_word_t    rdata
);

  prog_word_t mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/calc_sequencer.sv
// calc_sequencer
//   Runs a stored program on the calc stack calculator. On start it clears
//   calc for one cycle, then for each word issues op/in with a one-cycle apply
//   pulse and checks calc_valid on the following cycle. Ends on the word with
//   last set, on the final memory word, on the first invalid result, or on
//   abort.
//   Ports:
//     clk, rst (async, active low)
//     prog_we/prog_addr/prog_op/prog_data/prog_last - program load (IDLE only)
//     start, abort                                  - run control
//     busy, done, error, err_pc, result, result_empty - run status / outputs
//     calc_rst, calc_op, calc_in, calc_apply        - drive to calc
//     calc_tail, calc_empty, calc_valid             - from calc
module calc_sequencer
  import calc_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [2:0]    prog_op,
  input  logic [7:0]    prog_data,
  input  logic          prog_last,
  input  logic          start,
  input  logic          abort,
  output logic          busy,
  output logic          done,
  output logic          error,
  output logic [AW-1:0] err_pc,
  output logic [7:0]    result,
  output logic          result_empty,
  output logic          calc_rst,
  output logic [2:0]    calc_op,
  output logic [7:0]    calc_in,
  output logic          calc_apply,
  input  logic [7:0]    calc_tail,
  input  logic          calc_empty,
  input  logic          calc_valid
);

  localparam logic [AW-1:0] PC_MAX = AW'(DEPTH - 1);

  seq_state_e    state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [AW-1:0] err_pc_q, err_pc_d;
  logic [7:0]    result_q, result_d;
  logic          result_empty_q, result_empty_d;
  logic          last_q, last_d;
  logic          calc_rst_q, calc_rst_d;
  logic          calc_apply_q, calc_apply_d;
  logic [2:0]    calc_op_q, calc_op_d;
  logic [7:0]    calc_in_q, calc_in_d;

  logic          mem_we;
  logic          abort_exit;
  prog_word_t    wr_word;
  prog_word_t    rd_word;

  assign wr_word = {prog_op, prog_data, prog_last};

  // The read port looks at the next pc so the word is ready to be registered
  // onto calc_op/calc_in on the same edge that enters ISSUE.
  calc_prog_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (prog_addr),
    .wdata (wr_word),
    .raddr (pc_d),
    .rdata (rd_word)
  );

  // Next-state / control. Does not look at rd_word, so the pc_d -> memory ->
  // datapath path below stays acyclic.
  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    err_pc_d       = err_pc_q;
    result_d       = result_q;
    result_empty_d = result_empty_q;
    mem_we         = 1'b0;
    abort_exit     = 1'b0;

    case (state_q)
      IDLE: begin
        mem_we = prog_we;
        if (start) begin
          state_d  = CLEAR;
          pc_d     = '0;
          err_pc_d = '0;
        end
      end
      CLEAR: begin
        if (abort) begin
          state_d    = IDLE;
          abort_exit = 1'b1;
        end else begin
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (abort) begin
          state_d    = IDLE;
          abort_exit = 1'b1;
        end else begin
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (abort) begin
          state_d    = IDLE;
          abort_exit = 1'b1;
        end else if (!calc_valid) begin
          state_d  = ERROR;
          err_pc_d = pc_q;
        end else if (last_q || (pc_q == PC_MAX)) begin
          // Latch on entry so result is already visible while done pulses.
          state_d        = DONE;
          result_d       = calc_tail;
          result_empty_d = calc_empty;
        end else begin
          state_d = ISSUE;
          pc_d    = pc_q + AW'(1);
        end
      end
      DONE:    state_d = IDLE;
      ERROR:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Registered calc drive: op/in/last are loaded only when entering ISSUE,
  // so op/in hold between apply pulses.
  always_comb begin
    calc_op_d    = calc_op_q;
    calc_in_d    = calc_in_q;
    last_d       = last_q;
    calc_apply_d = (state_d == ISSUE);
    calc_rst_d   = (state_d == CLEAR) || abort_exit;
    if (state_d == ISSUE) begin
      calc_op_d = rd_word.op;
      calc_in_d = rd_word.data;
      last_d    = rd_word.last;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= IDLE;
      pc_q           <= '0;
      err_pc_q       <= '0;
      result_q       <= '0;
      result_empty_q <= 1'b0;
      last_q         <= 1'b0;
      calc_rst_q     <= 1'b1;
      calc_apply_q   <= 1'b0;
      calc_op_q      <= '0;
      calc_in_q      <= '0;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      err_pc_q       <= err_pc_d;
      result_q       <= result_d;
      result_empty_q <= result_empty_d;
      last_q         <= last_d;
      calc_rst_q     <= calc_rst_d;
      calc_apply_q   <= calc_apply_d;
      calc_op_q      <= calc_op_d;
      calc_in_q      <= calc_in_d;
    end
  end

  assign busy         = (state_q == CLEAR) || (state_q == ISSUE) || (state_q == CHECK);
  assign done         = (state_q == DONE);
  assign error        = (state_q == ERROR);
  assign err_pc       = err_pc_q;
  assign result       = result_q;
  assign result_empty = result_empty_q;
  assign calc_rst     = calc_rst_q;
  assign calc_op      = calc_op_q;
  assign calc_in      = calc_in_q;
  assign calc_apply   = calc_apply_q;

endmodule

// File: tb/tb_calc_sequencer.sv
// tb_calc_sequencer
//   Bench for calc_sequencer with a behavioural 16-deep calc stack model.
//   Table-driven programs feed a scoreboard of expected run outcomes; hand
//   sequences cover full-depth run, abort, ignored writes/start, async reset.
module tb_calc_sequencer;
  import calc_pkg::*;

  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          clk;
  logic          rst;
  logic          prog_we;
  logic [AW-1:0] prog_addr;
  logic [2:0]    prog_op;
  logic [7:0]    prog_data;
  logic          prog_last;
  logic          start;
  logic          abort;
  logic          busy, done, error;
  logic [AW-1:0] err_pc;
  logic [7:0]    result;
  logic          result_empty;
  logic          calc_rst;
  logic [2:0]    calc_op;
  logic [7:0]    calc_in;
  logic          calc_apply;
  logic [7:0]    calc_tail;
  logic          calc_empty;
  logic          calc_valid;

  calc_sequencer #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk          (clk),
    .rst          (rst),
    .prog_we      (prog_we),
    .prog_addr    (prog_addr),
    .prog_op      (prog_op),
    .prog_data    (prog_data),
    .prog_last    (prog_last),
    .start        (start),
    .abort        (abort),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .err_pc       (err_pc),
    .result       (result),
    .result_empty (result_empty),
    .calc_rst     (calc_rst),
    .calc_op      (calc_op),
    .calc_in      (calc_in),
    .calc_apply   (calc_apply),
    .calc_tail    (calc_tail),
    .calc_empty   (calc_empty),
    .calc_valid   (calc_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- calc model: 16-deep signed stack ----------------
  logic [4:0]        sp;
  logic signed [7:0] stk [16];
  logic              cv;
  logic [3:0]        t0, t1;
  assign t0 = sp[3:0] - 4'd1;
  assign t1 = sp[3:0] - 4'd2;

  always_ff @(posedge clk) begin
    if (calc_rst) begin
      sp <= 5'd0;
      cv <= 1'b1;
    end else if (calc_apply) begin
      cv <= 1'b0;
      case (calc_op)
        OP_PUSH: if (sp < 5'd16) begin stk[sp[3:0]] <= calc_in; sp <= sp + 5'd1; cv <= 1'b1; end
        OP_POP:  if (sp >= 5'd1) begin sp <= sp - 5'd1; cv <= 1'b1; end
        OP_NEG:  if (sp >= 5'd1) begin stk[t0] <= -stk[t0]; cv <= 1'b1; end
        OP_ADD:  if (sp >= 5'd2) begin stk[t1] <= stk[t1] + stk[t0]; sp <= sp - 5'd1; cv <= 1'b1; end
        OP_SUB:  if (sp >= 5'd2) begin stk[t1] <= stk[t1] - stk[t0]; sp <= sp - 5'd1; cv <= 1'b1; end
        OP_MUL:  if (sp >= 5'd2) begin stk[t1] <= stk[t1] * stk[t0]; sp <= sp - 5'd1; cv <= 1'b1; end
        default: ;
      endcase
    end
  end

  assign calc_tail  = (sp == 5'd0) ? 8'd0 : stk[t0];
  assign calc_empty = (sp == 5'd0);
  assign calc_valid = cv;

  // ---------------- checking ----------------
  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    bit          is_err;
    logic [7:0]  res;
    bit          emp;
    int          epc;
    int          napply;
    int          lat;
  } exp_t;

  exp_t       sb_q[$];
  logic [7:0] prev_res = 8'd0;
  bit         prev_emp = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  typedef struct {
    int              n;
    logic [3:0][2:0] op;
    logic [3:0][7:0] data;
    bit              is_err;
    logic [7:0]      res;
    bit              emp;
    int              epc;
  } vec_t;

  function automatic vec_t mkv(input int n,
                               input logic [2:0] o0, input logic [7:0] d0,
                               input logic [2:0] o1, input logic [7:0] d1,
                               input logic [2:0] o2, input logic [7:0] d2,
                               input bit e, input logic [7:0] r, input bit em, input int ep);
    vec_t v;
    v.n = n;
    v.op = '0;
    v.data = '0;
    v.op[0] = o0; v.data[0] = d0;
    v.op[1] = o1; v.data[1] = d1;
    v.op[2] = o2; v.data[2] = d2;
    v.is_err = e; v.res = r; v.emp = em; v.epc = ep;
    return v;
  endfunction

  // All stimulus tasks are entered just after a falling edge.
  task automatic load_word(input int a, input logic [2:0] op, input logic [7:0] d, input bit last);
    prog_we   = 1'b1;
    prog_addr = a[AW-1:0];
    prog_op   = op;
    prog_data = d;
    prog_last = last;
    @(negedge clk);
    prog_we   = 1'b0;
  endtask

  task automatic load_prog1();
    load_word(0, OP_PUSH, 8'd62, 1'b0);
    load_word(1, OP_PUSH, 8'd12, 1'b0);
    load_word(2, OP_ADD,  8'd0,  1'b1);
  endtask

  // Expected outcome of the next run; latency counts cycles after the start cycle.
  task automatic expect_run(input bit is_err, input logic [7:0] res, input bit emp,
                            input int epc, input int napply);
    exp_t e;
    e.is_err = is_err;
    e.epc    = epc;
    e.napply = napply;
    if (is_err) begin
      e.res = prev_res;
      e.emp = prev_emp;
      e.lat = 2 * epc + 4;
    end else begin
      e.res = res;
      e.emp = emp;
      e.lat = 2 * napply + 2;
      prev_res = res;
      prev_emp = emp;
    end
    sb_q.push_back(e);
  endtask

  // Start a run, watch it until done/error, pop and compare the scoreboard.
  // inject: write word 0 and re-assert start mid-run (both must be ignored).
  task automatic run_and_check(input string tag, input bit inject);
    int   c, napp, nbusy;
    bit   got;
    exp_t e;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    c = 1; napp = 0; nbusy = 0; got = 1'b0;
    while (c <= 200) begin
      if (inject && c == 3) begin
        prog_we = 1'b1; prog_addr = '0; prog_op = OP_PUSH; prog_data = 8'd99; prog_last = 1'b1;
        start = 1'b1;
      end else if (inject && c == 4) begin
        prog_we = 1'b0;
        start = 1'b0;
      end
      if (calc_apply) napp++;
      if (busy) nbusy++;
      if (done || error) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
      c++;
    end
    prog_we = 1'b0;
    start = 1'b0;
    if (!got) begin
      n_cmp++; n_bad++;
      $display("FAIL %s_timeout: got no done/error, expected one within 200 cycles", tag);
    end else if (sb_q.size() == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL %s_scoreboard: got a run end, expected no pending run", tag);
    end else begin
      e = sb_q.pop_front();
      chk({tag, "_error"}, 32'(error), 32'(e.is_err));
      chk({tag, "_done"}, 32'(done), 32'(!e.is_err));
      chk({tag, "_busy_at_end"}, 32'(busy), 32'd0);
      chk({tag, "_result"}, 32'(result), 32'(e.res));
      chk({tag, "_result_empty"}, 32'(result_empty), 32'(e.emp));
      if (e.is_err) chk({tag, "_err_pc"}, 32'(err_pc), 32'(e.epc));
      chk({tag, "_applies"}, 32'(napp), 32'(e.napply));
      chk({tag, "_latency"}, 32'(c), 32'(e.lat));
      chk({tag, "_busy_cycles"}, 32'(nbusy), 32'(e.lat - 1));
      $display("run %s: err=%0d result=%0h empty=%0d err_pc=%0d applies=%0d cycles=%0d",
               tag, error, result, result_empty, err_pc, napp, c);
    end
    @(negedge clk);
  endtask

  vec_t vecs[8];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish, expected end within 1 ms");
    $fatal(1, "watchdog");
  end

  initial begin
    int c, napp, nev;
    rst = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_op = '0; prog_data = '0;
    prog_last = 1'b0; start = 1'b0; abort = 1'b0;

    vecs[0] = mkv(3, OP_PUSH, 8'd62,  OP_PUSH, 8'd12,  OP_ADD, 8'd0, 1'b0, 8'd74,  1'b0, 0);
    vecs[1] = mkv(2, OP_PUSH, 8'd5,   OP_ADD,  8'd0,   OP_ADD, 8'd0, 1'b1, 8'd0,   1'b0, 1);
    vecs[2] = mkv(3, OP_PUSH, 8'd10,  OP_PUSH, 8'd3,   OP_SUB, 8'd0, 1'b0, 8'd7,   1'b0, 0);
    vecs[3] = mkv(3, OP_PUSH, 8'd100, OP_PUSH, 8'd100, OP_ADD, 8'd0, 1'b0, 8'hC8,  1'b0, 0);
    vecs[4] = mkv(3, OP_PUSH, 8'hFD,  OP_PUSH, 8'd7,   OP_MUL, 8'd0, 1'b0, 8'hEB,  1'b0, 0);
    vecs[5] = mkv(3, OP_PUSH, 8'd9,   OP_NEG,  8'd0,   OP_POP, 8'd0, 1'b0, 8'h00,  1'b1, 0);
    vecs[6] = mkv(1, OP_POP,  8'd0,   OP_POP,  8'd0,   OP_POP, 8'd0, 1'b1, 8'd0,   1'b0, 0);
    vecs[7] = mkv(2, OP_PUSH, 8'd4,   OP_NEG,  8'd0,   OP_POP, 8'd0, 1'b0, 8'hFC,  1'b0, 0);

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_calc_apply", 32'(calc_apply), 32'd0);
    chk("rst_calc_rst", 32'(calc_rst), 32'd1);
    chk("rst_outputs", {8'(calc_op), calc_in, result, 3'd0, result_empty, 4'(err_pc)}, 32'd0);
    $display("reset: busy=%0d calc_rst=%0d result=%0h", busy, calc_rst, result);
    rst = 1'b1;
    @(negedge clk);
    chk("idle_calc_rst", 32'(calc_rst), 32'd0);

    // Table-driven programs
    for (int i = 0; i < 8; i++) begin
      for (int w = 0; w < vecs[i].n; w++)
        load_word(w, vecs[i].op[w], vecs[i].data[w], (w == vecs[i].n - 1));
      expect_run(vecs[i].is_err, vecs[i].res, vecs[i].emp, vecs[i].epc,
                 vecs[i].is_err ? vecs[i].epc + 1 : vecs[i].n);
      run_and_check($sformatf("vec%0d", i), 1'b0);
    end

    // Full-depth program with no last bit: stops at DEPTH-1, no wrap
    for (int w = 0; w < DEPTH; w++) load_word(w, OP_PUSH, 8'd1, 1'b0);
    expect_run(1'b0, 8'd1, 1'b0, 0, DEPTH);
    run_and_check("full_depth", 1'b0);
    napp = 0;
    for (int k = 0; k < 6; k++) begin
      if (calc_apply || busy) napp++;
      @(negedge clk);
    end
    chk("full_depth_no_wrap", 32'(napp), 32'd0);

    // Abort in the second ISSUE cycle
    load_prog1();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    napp = 0;
    for (c = 1; c < 4; c++) begin
      if (calc_apply) napp++;
      @(negedge clk);
    end
    if (calc_apply) napp++;           // c == 4, second ISSUE
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_calc_rst", 32'(calc_rst), 32'd1);
    chk("abort_no_pulse", {30'd0, done, error}, 32'd0);
    @(negedge clk);
    chk("abort_calc_rst_one_cycle", 32'(calc_rst), 32'd0);
    nev = 0;
    for (int k = 0; k < 10; k++) begin
      if (calc_apply) napp++;
      if (done || error || busy) nev++;
      @(negedge clk);
    end
    chk("abort_applies", 32'(napp), 32'd2);
    chk("abort_quiet", 32'(nev), 32'd0);
    chk("abort_result_kept", 32'(result), 32'(prev_res));
    $display("abort: applies=%0d events_after=%0d result=%0h", napp, nev, result);

    // Write and second start during a run are ignored; re-run matches
    expect_run(1'b0, 8'd74, 1'b0, 0, 3);
    run_and_check("ignored_we_start", 1'b1);
    expect_run(1'b0, 8'd74, 1'b0, 0, 3);
    run_and_check("rerun", 1'b0);

    // Asynchronous reset mid-run, off-edge
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_calc_rst", 32'(calc_rst), 32'd1);
    chk("arst_apply", 32'(calc_apply), 32'd0);
    chk("arst_outputs", {8'(calc_op), calc_in, result, 3'd0, result_empty, 4'(err_pc)}, 32'd0);
    $display("async reset: busy=%0d calc_rst=%0d result=%0h", busy, calc_rst, result);
    @(negedge clk);
    @(negedge clk);
    chk("arst_calc_rst_held", 32'(calc_rst), 32'd1);
    rst = 1'b1;
    prev_res = 8'd0;
    prev_emp = 1'b0;
    @(negedge clk);
    expect_run(1'b0, 8'd74, 1'b0, 0, 3);
    run_and_check("after_arst", 1'b0);

    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
